// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR. A circular delay line and a
// runtime-loadable coefficient file feed one shared multiply-accumulate that
// handles one tap per clock. Optional build macro FIR_SEQ_SAT_EN clamps
// out_data at its maximum instead of wrapping modulo 2^OUT_W.
module fir_mac_sequencer #(
  parameter int TAPS  = 8,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OUT_W = 17,
  localparam int AW    = $clog2(TAPS),
  localparam int ACC_W = DW + CW + AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [CW-1:0]    coef_wdata,
  output logic             coef_err,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [DW-1:0]     x_mem    [TAPS];
  logic [CW-1:0]     coef_mem [TAPS];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     base_reg;
  logic [AW-1:0]     k_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [AW-1:0]     tap_idx;
  logic [DW+CW-1:0]  product;
  logic [OUT_W-1:0]  out_next;

  // x[n-k] lives at base-k; the AW-bit subtraction wraps because TAPS is a power of 2
  assign tap_idx = base_reg - k_reg;
  assign product = coef_mem[k_reg] * x_mem[tap_idx];

`ifdef FIR_SEQ_SAT_EN
  localparam logic [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  // clamp the final sum to the largest representable output
  always_comb begin
    out_next = acc_reg[OUT_W-1:0];
    if (acc_reg > OUT_MAX) begin
      out_next = '1;
    end
  end
`else
  logic acc_unused;
  // modulo wrap: the upper accumulator bits are intentionally dropped
  always_comb begin
    out_next   = acc_reg[OUT_W-1:0];
    acc_unused = ^acc_reg[ACC_W-1:OUT_W];
  end
`endif

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // next-state logic and handshake/status outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = S_MAC;
        end
      end
      S_MAC: begin
        if (k_reg == AW'(TAPS - 1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // delay line, coefficient file, MAC datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        x_mem[i]    <= '0;
        coef_mem[i] <= CW'(1);
      end
      wr_ptr_reg <= '0;
      base_reg   <= '0;
      k_reg      <= '0;
      acc_reg    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      coef_err   <= 1'b0;
    end else begin
      out_valid <= (state_reg == S_DONE);
      coef_err  <= coef_we && (state_reg != S_IDLE);
      case (state_reg)
        S_IDLE: begin
          // a coefficient written alongside a sample is already visible to its MAC
          if (coef_we) begin
            coef_mem[coef_addr] <= coef_wdata;
          end
          if (in_valid) begin
            x_mem[wr_ptr_reg] <= in_data;
            base_reg          <= wr_ptr_reg;
            wr_ptr_reg        <= wr_ptr_reg + 1'b1;
            acc_reg           <= '0;
            k_reg             <= '0;
          end
        end
        S_MAC: begin
          acc_reg <= acc_reg + ACC_W'(product);
          k_reg   <= k_reg + 1'b1;
        end
        S_DONE: begin
          out_data <= out_next;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: stimulus pushes the reference-model
// result for each accepted sample; a negedge monitor pops and compares on out_valid.
module tb_fir_mac_sequencer;
  localparam int TAPS  = 8;
  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int OUT_W = 17;
  localparam int AW    = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic             coef_we = 1'b0;
  logic [AW-1:0]    coef_addr = '0;
  logic [CW-1:0]    coef_wdata = '0;
  logic             coef_err;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             busy;

  fir_mac_sequencer #(.TAPS(TAPS), .DW(DW), .CW(CW), .OUT_W(OUT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_err(coef_err), .out_valid(out_valid),
    .out_data(out_data), .busy(busy)
  );

  always #5 clock = ~clock;

  int      checks = 0;
  int      errors = 0;
  longint  exp_q[$];
  int      hist[$];
  int      coef_m[TAPS];
  longint  last_out = 0;
  longint  cycle = 0;
  longint  accept_cycle[$];

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  // FIR definition: y[n] = sum_k coef[k]*x[n-k], missing history counts as 0
  function automatic longint model_y();
    longint s = 0;
    int n = hist.size();
    for (int k = 0; k < TAPS; k++) begin
      if (n - 1 - k >= 0) s += longint'(coef_m[k]) * longint'(hist[n - 1 - k]);
    end
`ifdef FIR_SEQ_SAT_EN
    if (s > (longint'(1) << OUT_W) - 1) s = (longint'(1) << OUT_W) - 1;
`else
    s = s % (longint'(1) << OUT_W);
`endif
    return s;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < TAPS; k++) coef_m[k] = 1;
  endtask

  // monitor: one comparison per out_valid pulse
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=%0d required=none", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
      last_out = out_data;
    end
  end

  task automatic wait_ready();
    int cnt = 0;
    while (!in_ready && cnt < 100) begin
      @(negedge clock);
      cnt++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
  endtask

  task automatic send(input int d, input bit do_w, input int wa, input int wd);
    @(negedge clock);
    wait_ready();
    in_valid   = 1'b1;
    in_data    = DW'(d);
    coef_we    = do_w;
    coef_addr  = AW'(wa);
    coef_wdata = CW'(wd);
    @(posedge clock);
    if (do_w) coef_m[wa] = wd;
    hist.push_back(d);
    exp_q.push_back(model_y());
    accept_cycle.push_back(cycle);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic write_coef(input int wa, input int wd);
    @(negedge clock);
    wait_ready();
    coef_we    = 1'b1;
    coef_addr  = AW'(wa);
    coef_wdata = CW'(wd);
    @(posedge clock);
    coef_m[wa] = wd;
    #1;
    coef_we = 1'b0;
  endtask

  task automatic drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      @(negedge clock);
      cnt++;
    end
    @(negedge clock);
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clock);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_coef_err"}, coef_err, 0);
  endtask

  initial begin
    model_reset();
    // reset held three cycles
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_idle_outputs("reset");

    // impulse with unit coefficients, then delay-line wrap to zero
    send(100, 0, 0, 0);
    for (int i = 0; i < 15; i++) send(0, 0, 0, 0);
    drain();

    // back-to-back samples of 10: running sums, one accept per TAPS+2 cycles
    accept_cycle.delete();
    for (int i = 0; i < 11; i++) send(10, 0, 0, 0);
    for (int i = 1; i < 11; i++)
      check("accept_period", accept_cycle[i] - accept_cycle[i-1], TAPS + 2);
    drain();

    // ramp coefficients, impulse response, and a write attempted during MAC
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    for (int i = 0; i < TAPS; i++) send(0, 0, 0, 0);
    drain();
    send(1, 0, 0, 0);
    @(negedge clock);
    coef_we    = 1'b1;
    coef_addr  = '0;
    coef_wdata = 8'd99;
    @(posedge clock);
    #1 coef_we = 1'b0;
    @(negedge clock);
    check("coef_err_pulse", coef_err, 1);
    @(negedge clock);
    check("coef_err_clear", coef_err, 0);
    for (int i = 0; i < TAPS; i++) send(0, 0, 0, 0);
    drain();

    // full-scale: all coefficients and samples at 255
    for (int k = 0; k < TAPS; k++) write_coef(k, 255);
    for (int i = 0; i < TAPS; i++) send(255, 0, 0, 0);
    drain();
`ifdef FIR_SEQ_SAT_EN
    check("full_scale_out", last_out, 131071);
`else
    check("full_scale_out", last_out, 126984);
`endif

    // randomized samples with occasional coefficient writes, some simultaneous
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) write_coef($urandom_range(0, TAPS - 1), $urandom_range(0, 255));
      send($urandom_range(0, 255), $urandom_range(0, 2) == 0,
           $urandom_range(0, TAPS - 1), $urandom_range(0, 255));
    end
    drain();

    // reset mid-MAC (k=3) aborts the sample; coefficients return to 1
    send(77, 0, 0, 0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    void'(exp_q.pop_back());
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_idle_outputs("midreset");
    repeat (15) @(negedge clock);
    send(50, 0, 0, 0);
    drain();
    check("after_reset_out", last_out, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
